// File: rtl/pulse_meter_pkg.sv
// Shared types and 12 MHz default constants for the pulse period meter.
package pulse_meter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MEASURE,
    TIMEOUT
  } meter_state_t;

  localparam int unsigned CLK_HZ            = 12_000_000;
  localparam int unsigned ONE_SECOND_CYCLES = CLK_HZ;

endpackage

// File: rtl/rising_edge_detect.sv
// Rising-edge detector with optional 2-flop input synchronizer.
// Build option: PULSE_METER_SYNC_EN adds the synchronizer (2 clk extra latency).
module rising_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic d_s;
  logic pulse_q;

`ifdef PULSE_METER_SYNC_EN
  logic [1:0] sync_q;

  // Two-stage synchronizer for an asynchronous pulse source.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], d};
    end
  end

  assign d_s = sync_q[1];
`else
  assign d_s = d;
`endif

  // Delayed copy of the (possibly synchronized) input for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pulse_q <= 1'b0;
    end else begin
      pulse_q <= d_s;
    end
  end

  assign rise = d_s & ~pulse_q;

endmodule

// File: rtl/pulse_period_meter.sv
// Measures the clk-cycle interval between rising edges of pulse_in, flags
// loss of pulses (timeout) and lock onto a period near EXPECTED.
// Build option: PULSE_METER_SYNC_EN inserts a 2-flop synchronizer on pulse_in.
module pulse_period_meter
  import pulse_meter_pkg::*;
#(
  parameter int unsigned WIDTH          = 24,
  parameter int unsigned EXPECTED       = ONE_SECOND_CYCLES,
  parameter int unsigned TOL            = 1_200,
  parameter int unsigned TIMEOUT_CYCLES = 16_000_000,
  parameter int unsigned LOCK_COUNT     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pulse_in,
  output logic [WIDTH-1:0] period,
  output logic             period_valid,
  output logic             locked,
  output logic             timeout
);

  // One extra bit so |period - EXPECTED| never wraps.
  localparam logic [WIDTH:0]   ExpW     = (WIDTH+1)'(EXPECTED);
  localparam logic [WIDTH:0]   TolW     = (WIDTH+1)'(TOL);
  localparam logic [WIDTH-1:0] TimeoutW = WIDTH'(TIMEOUT_CYCLES);
  localparam logic [3:0]       LockW    = 4'(LOCK_COUNT);

  logic             rise;
  meter_state_t     state_q, state_d;
  logic [WIDTH-1:0] counter_q, counter_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic             valid_q, valid_d;
  logic             locked_q, locked_d;
  logic             timeout_q, timeout_d;
  logic [3:0]       lock_cnt_q, lock_cnt_d;
  logic [WIDTH:0]   cnt_ext;
  logic [WIDTH:0]   diff;
  logic             in_tol;

  rising_edge_detect u_edge (
    .clk  (clk),
    .rst  (rst),
    .d    (pulse_in),
    .rise (rise)
  );

  // Tolerance test on the interval about to be reported.
  always_comb begin
    cnt_ext = {1'b0, counter_q};
    diff    = (cnt_ext >= ExpW) ? (cnt_ext - ExpW) : (ExpW - cnt_ext);
    in_tol  = (diff <= TolW);
  end

  // Next-state logic: FSM, interval counter, period capture and lock tracking.
  always_comb begin
    state_d    = state_q;
    counter_d  = counter_q;
    period_d   = period_q;
    valid_d    = 1'b0;
    locked_d   = locked_q;
    timeout_d  = timeout_q;
    lock_cnt_d = lock_cnt_q;
    unique case (state_q)
      IDLE: begin
        counter_d = '0;
        if (rise) begin
          state_d   = MEASURE;
          counter_d = WIDTH'(1);
        end
      end
      MEASURE: begin
        if (rise) begin
          // A rise coinciding with the timeout threshold still counts as a period.
          period_d  = counter_q;
          valid_d   = 1'b1;
          counter_d = WIDTH'(1);
          if (in_tol) begin
            if (lock_cnt_q < LockW) lock_cnt_d = lock_cnt_q + 4'd1;
            if (lock_cnt_d >= LockW) locked_d = 1'b1;
          end else begin
            lock_cnt_d = '0;
            locked_d   = 1'b0;
          end
        end else if (counter_q == TimeoutW) begin
          state_d    = TIMEOUT;
          timeout_d  = 1'b1;
          locked_d   = 1'b0;
          lock_cnt_d = '0;
        end else begin
          counter_d = counter_q + WIDTH'(1);
        end
      end
      TIMEOUT: begin
        // Counter stays frozen; the recovering edge only restarts measurement.
        if (rise) begin
          state_d   = MEASURE;
          counter_d = WIDTH'(1);
          timeout_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      counter_q  <= '0;
      period_q   <= '0;
      valid_q    <= 1'b0;
      locked_q   <= 1'b0;
      timeout_q  <= 1'b0;
      lock_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      counter_q  <= counter_d;
      period_q   <= period_d;
      valid_q    <= valid_d;
      locked_q   <= locked_d;
      timeout_q  <= timeout_d;
      lock_cnt_q <= lock_cnt_d;
    end
  end

  assign period       = period_q;
  assign period_valid = valid_q;
  assign locked       = locked_q;
  assign timeout      = timeout_q;

endmodule

// File: tb/tb_pulse_period_meter.sv
// Directed self-checking bench for pulse_period_meter (EXPECTED=100, TOL=2,
// TIMEOUT_CYCLES=300, LOCK_COUNT=4). Build with PULSE_METER_SYNC_EN to cover
// the synchronized variant: all responses shift by 2 clk.
module tb_pulse_period_meter;
  import pulse_meter_pkg::*;

  localparam int W = 24;
`ifdef PULSE_METER_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         pulse_in = 1'b0;
  logic [W-1:0] period;
  logic         period_valid;
  logic         locked;
  logic         timeout;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  pulse_period_meter #(
    .WIDTH          (W),
    .EXPECTED       (100),
    .TOL            (2),
    .TIMEOUT_CYCLES (300),
    .LOCK_COUNT     (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .pulse_in     (pulse_in),
    .period       (period),
    .period_valid (period_valid),
    .locked       (locked),
    .timeout      (timeout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Event recorders: strobes and timeout transitions, sampled on the falling edge.
  typedef struct {int c; logic [W-1:0] p; logic lk;} strobe_t;
  typedef struct {int c; logic v; logic lk;} to_t;
  strobe_t sq[$];
  to_t     tq[$];
  logic    to_prev = 1'b0;

  always @(negedge clk) begin
    if (period_valid === 1'b1) sq.push_back('{cyc, period, locked});
    if (timeout !== to_prev) begin
      tq.push_back('{cyc, timeout, locked});
      to_prev <= timeout;
    end
  end

  task automatic wait_cyc(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Rise at cycle c, held high for w cycles.
  task automatic drive_pulse(input int c, input int w);
    wait_cyc(c);
    pulse_in = 1'b1;
    wait_cyc(c + w);
    pulse_in = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    pulse_in = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    sq.delete();
    tq.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    pulse_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (period !== '0) begin errors++; $display("FAIL reset_period got %0d exp 0", period); end
    checks++;
    if ({period_valid, locked, timeout} !== 3'b000) begin
      errors++; $display("FAIL reset_flags got %b exp 000", {period_valid, locked, timeout});
    end
    checks++;
    if (dut.state_q !== IDLE) begin errors++; $display("FAIL reset_state got %0d exp 0", dut.state_q); end
    do_reset();
  endtask

  task automatic test_lock_acquire(input string tag);
    int r;
    do_reset();
    r = cyc + 2;
    for (int k = 0; k < 6; k++) drive_pulse(r + 100 * k, 1);
    wait_cyc(r + 500 + LAT + 2);
    checks++;
    if (sq.size() !== 5) begin errors++; $display("FAIL %s_count got %0d exp 5", tag, sq.size()); end
    for (int i = 0; i < sq.size() && i < 5; i++) begin
      checks++;
      if (sq[i].c !== r + 100 * (i + 1) + LAT) begin
        errors++; $display("FAIL %s_time[%0d] got %0d exp %0d", tag, i, sq[i].c, r + 100 * (i + 1) + LAT);
      end
      checks++;
      if (sq[i].p !== 24'd100) begin errors++; $display("FAIL %s_period[%0d] got %0d exp 100", tag, i, sq[i].p); end
      checks++;
      if (sq[i].lk !== (i >= 3)) begin
        errors++; $display("FAIL %s_locked[%0d] got %b exp %b", tag, i, sq[i].lk, (i >= 3));
      end
    end
    checks++;
    if (tq.size() !== 0) begin errors++; $display("FAIL %s_no_timeout got %0d exp 0", tag, tq.size()); end
  endtask

  task automatic test_lock_loss();
    int r;
    int rises[9];
    int exp_p[9];
    logic exp_lk[9];
    rises = '{0, 100, 200, 300, 400, 510, 608, 708, 808};
    exp_p = '{0, 100, 100, 100, 100, 110, 98, 100, 100};
    exp_lk = '{0, 0, 0, 0, 1, 0, 0, 0, 0};
    do_reset();
    r = cyc + 2;
    for (int k = 0; k < 9; k++) drive_pulse(r + rises[k], 1);
    drive_pulse(r + 908, 1);
    wait_cyc(r + 908 + LAT + 2);
    checks++;
    if (sq.size() !== 9) begin errors++; $display("FAIL loss_count got %0d exp 9", sq.size()); end
    for (int i = 0; i < sq.size() && i < 9; i++) begin
      // Strobe i reports the interval ending at rise i+1.
      checks++;
      if (sq[i].p !== W'(i < 8 ? exp_p[i + 1] : 100)) begin
        errors++; $display("FAIL loss_period[%0d] got %0d exp %0d", i, sq[i].p, (i < 8 ? exp_p[i + 1] : 100));
      end
      checks++;
      if (sq[i].lk !== (i < 8 ? exp_lk[i + 1] : 1'b1)) begin
        errors++; $display("FAIL loss_locked[%0d] got %b exp %b", i, sq[i].lk, (i < 8 ? exp_lk[i + 1] : 1'b1));
      end
    end
  endtask

  task automatic test_timeout(input string tag);
    int r;
    do_reset();
    r = cyc + 2;
    for (int k = 0; k < 5; k++) drive_pulse(r + 100 * k, 1);
    wait_cyc(r + 400 + 300 + LAT + 5);
    checks++;
    if (sq.size() !== 4) begin errors++; $display("FAIL %s_prelock_count got %0d exp 4", tag, sq.size()); end
    else begin
      checks++;
      if (sq[3].lk !== 1'b1) begin errors++; $display("FAIL %s_prelock got %b exp 1", tag, sq[3].lk); end
    end
    checks++;
    if (tq.size() !== 1) begin errors++; $display("FAIL %s_to_events got %0d exp 1", tag, tq.size()); end
    else begin
      checks++;
      if (tq[0].c !== r + 700 + LAT || tq[0].v !== 1'b1 || tq[0].lk !== 1'b0) begin
        errors++; $display("FAIL %s_to_set got c=%0d v=%b lk=%b exp c=%0d v=1 lk=0",
                           tag, tq[0].c, tq[0].v, tq[0].lk, r + 700 + LAT);
      end
    end
    checks++;
    if (period !== 24'd100) begin errors++; $display("FAIL %s_period_hold got %0d exp 100", tag, period); end
    drive_pulse(r + 800, 1);
    drive_pulse(r + 900, 1);
    wait_cyc(r + 900 + LAT + 2);
    checks++;
    if (tq.size() !== 2) begin errors++; $display("FAIL %s_to_clear_count got %0d exp 2", tag, tq.size()); end
    else begin
      checks++;
      if (tq[1].c !== r + 800 + LAT || tq[1].v !== 1'b0) begin
        errors++; $display("FAIL %s_to_clear got c=%0d v=%b exp c=%0d v=0", tag, tq[1].c, tq[1].v, r + 800 + LAT);
      end
    end
    checks++;
    if (sq.size() !== 5) begin errors++; $display("FAIL %s_recover_count got %0d exp 5", tag, sq.size()); end
    else begin
      checks++;
      if (sq[4].c !== r + 900 + LAT || sq[4].p !== 24'd100) begin
        errors++; $display("FAIL %s_recover got c=%0d p=%0d exp c=%0d p=100", tag, sq[4].c, sq[4].p, r + 900 + LAT);
      end
    end
  endtask

  task automatic test_held_high();
    int r;
    do_reset();
    r = cyc + 2;
    for (int k = 0; k < 5; k++) drive_pulse(r + 100 * k, 50);
    wait_cyc(r + 400 + LAT + 2);
    checks++;
    if (sq.size() !== 4) begin errors++; $display("FAIL held_count got %0d exp 4", sq.size()); end
    for (int i = 0; i < sq.size() && i < 4; i++) begin
      checks++;
      if (sq[i].p !== 24'd100 || sq[i].c !== r + 100 * (i + 1) + LAT) begin
        errors++; $display("FAIL held_strobe[%0d] got c=%0d p=%0d exp c=%0d p=100",
                           i, sq[i].c, sq[i].p, r + 100 * (i + 1) + LAT);
      end
    end
  endtask

  task automatic test_reset_mid();
    int r;
    do_reset();
    r = cyc + 2;
    drive_pulse(r, 1);
    drive_pulse(r + 100, 1);
    wait_cyc(r + 160);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (period !== '0) begin errors++; $display("FAIL midrst_period got %0d exp 0", period); end
    checks++;
    if ({period_valid, locked, timeout} !== 3'b000) begin
      errors++; $display("FAIL midrst_flags got %b exp 000", {period_valid, locked, timeout});
    end
    checks++;
    if (dut.state_q !== IDLE || dut.counter_q !== '0) begin
      errors++; $display("FAIL midrst_state got st=%0d cnt=%0d exp 0 0", dut.state_q, dut.counter_q);
    end
    test_lock_acquire("resume");
  endtask

  task automatic test_timeout_tie();
    int r;
    do_reset();
    r = cyc + 2;
    drive_pulse(r, 1);
    drive_pulse(r + 300, 1);
    wait_cyc(r + 300 + LAT + 5);
    checks++;
    if (sq.size() !== 1) begin errors++; $display("FAIL tie_count got %0d exp 1", sq.size()); end
    else begin
      checks++;
      if (sq[0].p !== 24'd300 || sq[0].c !== r + 300 + LAT) begin
        errors++; $display("FAIL tie_strobe got c=%0d p=%0d exp c=%0d p=300", sq[0].c, sq[0].p, r + 300 + LAT);
      end
    end
    checks++;
    if (tq.size() !== 0 || timeout !== 1'b0) begin
      errors++; $display("FAIL tie_no_timeout got events=%0d to=%b exp 0 0", tq.size(), timeout);
    end
  endtask

  initial begin
    test_reset();
    test_lock_acquire("acquire");
    test_lock_loss();
    test_timeout("timeout");
    test_held_high();
    test_reset_mid();
    test_timeout_tie();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
